cv32e41s_lsu_resp_unit: RTL and testbench

Producer end of the LSU→WB response handshake. Tracks in-order data-bus transactions issued from EX and captures OBI responses (rdata/err). Injects MPU-blocked and watchpoint-matched pseudo-responses that never reach the bus. Aligns, sign-extends and aggregates split misaligned loads, then presents one response per sub-operation to WB over a valid/ready handshake.

---
 rtl/cv32e41s_lsu_resp_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_cv32e41s_lsu_resp_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_lsu_resp_unit.sv
// cv32e41s_lsu_resp_unit
//   Response side of the LSU. It keeps in-order data-bus transactions that EX
//   issued and captures their OBI responses. Requests blocked by the MPU or a
//   watchpoint never reach the bus, so this block supplies their responses
//   itself. Split misaligned loads are aligned, extended and merged here. WB
//   receives one response per sub-operation over a valid/ready handshake.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_*                   sub-operation issued from EX (valid/ready)
//   bus_rvalid_i/rdata/err  OBI response channel
//   lsu_*                   response to WB (valid/ready, data, error, status)
//   cnt_o, busy_o           occupancy of the outstanding-transaction FIFO

package cv32e41s_lsu_resp_pkg;

    typedef enum logic [1:0] {
        MPU_OK       = 2'b00,
        MPU_RE_FAULT = 2'b01,
        MPU_WR_FAULT = 2'b10
    } mpu_status_e;

    typedef struct packed {
        logic        bus;
        logic        we;
        logic [1:0]  typ;
        logic        sext;
        logic [1:0]  offset;
        logic        split_first;
        logic        split_second;
        mpu_status_e mpu_status;
        logic [31:0] wpt_match;
        logic        done;
        logic [31:0] rdata;
        logic        err;
    } lsu_entry_t;

endpackage

module cv32e41s_lsu_resp_unit
    import cv32e41s_lsu_resp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_bus_i,
    input  logic                       req_we_i,
    input  logic [1:0]                 req_type_i,
    input  logic                       req_sext_i,
    input  logic [1:0]                 req_offset_i,
    input  logic                       req_split_first_i,
    input  logic                       req_split_second_i,
    input  mpu_status_e                req_mpu_status_i,
    input  logic [31:0]                req_wpt_match_i,

    input  logic                       bus_rvalid_i,
    input  logic [31:0]                bus_rdata_i,
    input  logic                       bus_err_i,

    output logic                       lsu_valid_o,
    input  logic                       lsu_ready_i,
    output logic [31:0]                lsu_rdata_o,
    output logic                       lsu_err_o,
    output mpu_status_e                lsu_mpu_status_o,
    output logic [31:0]                lsu_wpt_match_o,

    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    lsu_entry_t         ent_q [DEPTH];
    lsu_entry_t         ent_d [DEPTH];
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [PW-1:0]      rsp_ptr_q, rsp_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [31:0]        agg_q, agg_d;

    lsu_entry_t         head;
    lsu_entry_t         new_ent;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               rsp_legal;
    logic               rsp_accept;
    logic [4:0]         sh_first;
    logic [5:0]         sh_second;
    logic [31:0]        w_first;
    logic [31:0]        w_aligned;
    logic [31:0]        w_ext;

    assign head  = ent_q[rptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Blocked entries produce their response at push time, so they may only
    // enter an empty FIFO; otherwise they would overtake pending bus responses.
    assign req_ready_o = !full && (req_bus_i || empty);
    assign push        = req_valid_i && req_ready_o;

    assign lsu_valid_o = !empty && head.done;
    assign pop         = lsu_valid_o && lsu_ready_i;

    // When the FIFO is full, rsp_ptr == wptr still has a pending entry unless
    // that entry has already responded. Responses while empty are stale (for
    // example left over from before a reset) and are dropped.
    assign rsp_legal  = !empty && ((rsp_ptr_q != wptr_q) || full) && !ent_q[rsp_ptr_q].done;
    assign rsp_accept = bus_rvalid_i && rsp_legal;

    // Alignment of the head entry data
    assign sh_first  = {head.offset, 3'b000};
    assign sh_second = 6'd32 - {1'b0, head.offset, 3'b000};
    assign w_first   = head.rdata >> sh_first;

    always_comb begin
        w_aligned = w_first;
        if (head.split_second) begin
            w_aligned = (head.rdata << sh_second) | agg_q;
        end
    end

    always_comb begin
        w_ext = w_aligned;
        unique case (head.typ)
            2'b00:   w_ext = {{24{head.sext & w_aligned[7]}},  w_aligned[7:0]};
            2'b01:   w_ext = {{16{head.sext & w_aligned[15]}}, w_aligned[15:0]};
            default: w_ext = w_aligned;
        endcase
    end

    assign lsu_rdata_o      = (!empty && !head.we) ? w_ext : 32'h0;
    assign lsu_err_o        = !empty && head.err;
    assign lsu_mpu_status_o = empty ? MPU_OK : head.mpu_status;
    assign lsu_wpt_match_o  = empty ? 32'h0  : head.wpt_match;
    assign cnt_o            = count_q;
    assign busy_o           = !empty;

    always_comb begin
        new_ent              = '0;
        new_ent.bus          = req_bus_i;
        new_ent.we           = req_we_i;
        new_ent.typ          = req_type_i;
        new_ent.sext         = req_sext_i;
        new_ent.offset       = req_offset_i;
        new_ent.split_first  = req_split_first_i;
        new_ent.split_second = req_split_second_i;
        new_ent.mpu_status   = req_bus_i ? MPU_OK : req_mpu_status_i;
        new_ent.wpt_match    = req_bus_i ? 32'h0  : req_wpt_match_i;
        new_ent.done         = !req_bus_i;
        new_ent.rdata        = 32'h0;
        new_ent.err          = 1'b0;
    end

    always_comb begin
        ent_d     = ent_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rsp_ptr_d = rsp_ptr_q;
        count_d   = count_q;
        agg_d     = agg_q;

        if (pop) begin
            ent_d[rptr_q].done = 1'b0;
            rptr_d             = rptr_q + PW'(1);
            // Blocked or errored first halves still feed the aggregate.
            if (head.split_first) begin
                agg_d = w_first;
            end
        end

        if (push) begin
            ent_d[wptr_q] = new_ent;
            wptr_d        = wptr_q + PW'(1);
            if (!req_bus_i) begin
                rsp_ptr_d = rsp_ptr_q + PW'(1);
            end
        end

        // A blocked push needs an empty FIFO and an accepted response needs a
        // non-empty one, so the two never advance rsp_ptr together.
        if (rsp_accept) begin
            ent_d[rsp_ptr_q].rdata = bus_rdata_i;
            ent_d[rsp_ptr_q].err   = bus_err_i;
            ent_d[rsp_ptr_q].done  = 1'b1;
            rsp_ptr_d              = rsp_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            rsp_ptr_q <= '0;
            count_q   <= '0;
            agg_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rsp_ptr_q <= rsp_ptr_d;
            count_q   <= count_d;
            agg_q     <= agg_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing pending is a bus protocol violation.
    always @(posedge clk) begin
        if (rst_n && bus_rvalid_i && !empty) begin
            assert (rsp_legal)
                else $error("lsu_resp_unit: bus response without pending transaction");
        end
    end
`endif

endmodule

// File: tb/tb_cv32e41s_lsu_resp_unit.sv
// Directed testbench for cv32e41s_lsu_resp_unit (DEPTH = 2). The stimulus is a
// linear sequence of steps, and each comparison is an immediate assertion
// against a hand-computed value.
module tb_cv32e41s_lsu_resp_unit;
    import cv32e41s_lsu_resp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_bus_i;
    logic        req_we_i;
    logic [1:0]  req_type_i;
    logic        req_sext_i;
    logic [1:0]  req_offset_i;
    logic        req_split_first_i;
    logic        req_split_second_i;
    mpu_status_e req_mpu_status_i;
    logic [31:0] req_wpt_match_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;
    logic        lsu_valid_o;
    logic        lsu_ready_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    mpu_status_e lsu_mpu_status_o;
    logic [31:0] lsu_wpt_match_o;
    logic [1:0]  cnt_o;
    logic        busy_o;

    int vectors;
    int miscompares;

    cv32e41s_lsu_resp_unit #(.DEPTH(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_bus_i          (req_bus_i),
        .req_we_i           (req_we_i),
        .req_type_i         (req_type_i),
        .req_sext_i         (req_sext_i),
        .req_offset_i       (req_offset_i),
        .req_split_first_i  (req_split_first_i),
        .req_split_second_i (req_split_second_i),
        .req_mpu_status_i   (req_mpu_status_i),
        .req_wpt_match_i    (req_wpt_match_i),
        .bus_rvalid_i       (bus_rvalid_i),
        .bus_rdata_i        (bus_rdata_i),
        .bus_err_i          (bus_err_i),
        .lsu_valid_o        (lsu_valid_o),
        .lsu_ready_i        (lsu_ready_i),
        .lsu_rdata_o        (lsu_rdata_o),
        .lsu_err_o          (lsu_err_o),
        .lsu_mpu_status_o   (lsu_mpu_status_o),
        .lsu_wpt_match_o    (lsu_wpt_match_o),
        .cnt_o              (cnt_o),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    // Present one request for a single cycle; it is accepted if req_ready_o is high.
    task automatic issue(input logic bus, input logic we, input logic [1:0] typ,
                         input logic sext, input logic [1:0] off, input logic sf,
                         input logic ss, input mpu_status_e mpu, input logic [31:0] wpt);
        req_valid_i        = 1'b1;
        req_bus_i          = bus;
        req_we_i           = we;
        req_type_i         = typ;
        req_sext_i         = sext;
        req_offset_i       = off;
        req_split_first_i  = sf;
        req_split_second_i = ss;
        req_mpu_status_i   = mpu;
        req_wpt_match_i    = wpt;
        tick();
        req_valid_i        = 1'b0;
        req_bus_i          = 1'b1;
        req_split_first_i  = 1'b0;
        req_split_second_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        bus_err_i    = err;
        tick();
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_n              = 1'b0;
        req_valid_i        = 1'b0;
        req_bus_i          = 1'b1;
        req_we_i           = 1'b0;
        req_type_i         = 2'b10;
        req_sext_i         = 1'b0;
        req_offset_i       = 2'b00;
        req_split_first_i  = 1'b0;
        req_split_second_i = 1'b0;
        req_mpu_status_i   = MPU_OK;
        req_wpt_match_i    = 32'h0;
        bus_rvalid_i       = 1'b0;
        bus_rdata_i        = 32'h0;
        bus_err_i          = 1'b0;
        lsu_ready_i        = 1'b1;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid",  32'(lsu_valid_o), 32'd0);
        chk("rst_ready",  32'(req_ready_o), 32'd1);
        chk("rst_cnt",    32'(cnt_o), 32'd0);
        chk("rst_busy",   32'(busy_o), 32'd0);
        chk("rst_mpu",    32'(lsu_mpu_status_o), 32'(MPU_OK));
        chk("rst_wpt",    lsu_wpt_match_o, 32'h0);
        chk("rst_rdata",  lsu_rdata_o, 32'h0);
        chk("rst_err",    32'(lsu_err_o), 32'd0);

        // Aligned lw; the watchpoint input must not leak into a bus entry
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_RE_FAULT, 32'hFFFF_0000);
        chk("lw_cnt1", 32'(cnt_o), 32'd1);
        chk("lw_busy", 32'(busy_o), 32'd1);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("lw_no_comb_path", 32'(lsu_valid_o), 32'd0);
        tick();
        bus_rvalid_i = 1'b0;
        chk("lw_valid", 32'(lsu_valid_o), 32'd1);
        chk("lw_rdata", lsu_rdata_o, 32'hDEADBEEF);
        chk("lw_mpu",   32'(lsu_mpu_status_o), 32'(MPU_OK));
        chk("lw_wpt",   lsu_wpt_match_o, 32'h0);
        tick();
        chk("lw_cnt0",   32'(cnt_o), 32'd0);
        chk("lw_valid0", 32'(lsu_valid_o), 32'd0);

        // lb sign-extended, offset 3
        issue(1'b1, 1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0, MPU_OK, 32'h0);
        respond(32'h80112233, 1'b0);
        chk("lb_sext", lsu_rdata_o, 32'hFFFFFF80);
        tick();
        // lbu, offset 3
        issue(1'b1, 1'b0, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0, MPU_OK, 32'h0);
        respond(32'h80112233, 1'b0);
        chk("lbu", lsu_rdata_o, 32'h00000080);
        tick();
        // lh, offset 2
        issue(1'b1, 1'b0, 2'b01, 1'b1, 2'd2, 1'b0, 1'b0, MPU_OK, 32'h0);
        respond(32'h7FFF0000, 1'b0);
        chk("lh_pos", lsu_rdata_o, 32'h00007FFF);
        tick();
        // lh sign-extended, offset 0, with a bus error that must not suppress data
        issue(1'b1, 1'b0, 2'b01, 1'b1, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        respond(32'h1234_8001, 1'b1);
        chk("lh_neg_err_data", lsu_rdata_o, 32'hFFFF8001);
        chk("lh_neg_err",      32'(lsu_err_o), 32'd1);
        tick();
        // Store returns zero data
        issue(1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        respond(32'hA5A5A5A5, 1'b0);
        chk("sw_valid", 32'(lsu_valid_o), 32'd1);
        chk("sw_rdata", lsu_rdata_o, 32'h0);
        tick();

        // Split lw, offset 1
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd1, 1'b1, 1'b0, MPU_OK, 32'h0);
        respond(32'h44332211, 1'b0);
        chk("split1_rdata", lsu_rdata_o, 32'h00443322);
        tick();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 1'b1, MPU_OK, 32'h0);
        respond(32'h88776655, 1'b0);
        chk("split2_valid", 32'(lsu_valid_o), 32'd1);
        chk("split2_rdata", lsu_rdata_o, 32'h55443322);
        tick();
        chk("split_cnt0", 32'(cnt_o), 32'd0);

        // Back-to-back pushes with WB stalled
        lsu_ready_i = 1'b0;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        chk("b2b_cnt2",  32'(cnt_o), 32'd2);
        chk("b2b_ready", 32'(req_ready_o), 32'd0);
        respond(32'h11111111, 1'b0);
        respond(32'h22222222, 1'b0);
        chk("b2b_valid_stalled", 32'(lsu_valid_o), 32'd1);
        chk("b2b_rdata_a",       lsu_rdata_o, 32'h11111111);
        chk("b2b_cnt_stalled",   32'(cnt_o), 32'd2);
        lsu_ready_i = 1'b1;
        tick();
        chk("b2b_rdata_b", lsu_rdata_o, 32'h22222222);
        chk("b2b_cnt1",    32'(cnt_o), 32'd1);
        tick();
        chk("b2b_cnt0",    32'(cnt_o), 32'd0);

        // Blocked request waits for an outstanding bus transaction to drain
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        req_valid_i      = 1'b1;
        req_bus_i        = 1'b0;
        req_mpu_status_i = MPU_RE_FAULT;
        req_wpt_match_i  = 32'h0000_0005;
        #1;
        chk("blk_ready_wait", 32'(req_ready_o), 32'd0);
        tick();
        chk("blk_cnt_wait", 32'(cnt_o), 32'd1);
        respond(32'hCAFEF00D, 1'b0);
        chk("blk_head_valid", 32'(lsu_valid_o), 32'd1);
        chk("blk_head_rdata", lsu_rdata_o, 32'hCAFEF00D);
        chk("blk_ready_still0", 32'(req_ready_o), 32'd0);
        tick();
        chk("blk_ready_drained", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        req_bus_i   = 1'b1;
        chk("blk_valid", 32'(lsu_valid_o), 32'd1);
        chk("blk_mpu",   32'(lsu_mpu_status_o), 32'(MPU_RE_FAULT));
        chk("blk_wpt",   lsu_wpt_match_o, 32'h0000_0005);
        chk("blk_rdata", lsu_rdata_o, 32'h0);
        chk("blk_cnt",   32'(cnt_o), 32'd1);
        tick();
        chk("blk_cnt0",  32'(cnt_o), 32'd0);
        chk("blk_mpu_ok", 32'(lsu_mpu_status_o), 32'(MPU_OK));

        // Reset with two outstanding transactions, then a stale response
        lsu_ready_i = 1'b0;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, MPU_OK, 32'h0);
        respond(32'h33333333, 1'b0);
        chk("mid_cnt2", 32'(cnt_o), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_cnt",   32'(cnt_o), 32'd0);
        chk("mid_rst_valid", 32'(lsu_valid_o), 32'd0);
        chk("mid_rst_mpu",   32'(lsu_mpu_status_o), 32'(MPU_OK));
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        respond(32'h44444444, 1'b0);
        chk("late_rsp_cnt",   32'(cnt_o), 32'd0);
        chk("late_rsp_valid", 32'(lsu_valid_o), 32'd0);
        lsu_ready_i = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
